// File: rtl/load_store_unit.sv
// Load/store unit: initiator side of a 64-bit, word-indexed, synchronous-read
// data memory. Handles one request at a time, sub-word loads with zero/sign
// extension, and sub-word stores as read-modify-write.
module load_store_unit #(
  parameter int unsigned MEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  output logic [63:0] MemAdress,
  output logic [63:0] MemWriteData,
  output logic        MemWrite,
  output logic        MemRead,
  input  logic [63:0] MemReadData
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    WR      = 3'd3,
    RESP    = 3'd4
  } state_t;

  localparam logic [60:0] WORD_LIMIT = 61'(MEM_WORDS);

  state_t      state, state_nxt;
  logic        write_q, signed_q, err_q;
  logic [1:0]  size_q;
  logic [2:0]  off_q;
  logic [63:0] wdata_q;

  logic        accept, misaligned, out_of_range, req_err;
  logic [5:0]  shift;
  logic [63:0] rd_shifted, load_ext, size_mask, lane_mask, merged;

  assign accept       = req_valid && (state == IDLE);
  assign out_of_range = (req_addr[63:3] >= WORD_LIMIT);
  assign req_err      = misaligned || out_of_range;

  assign req_ready  = (state == IDLE);
  assign MemRead    = (state == RD_REQ);
  assign MemWrite   = (state == WR);
  assign resp_valid = (state == RESP);
  assign resp_err   = (state == RESP) && err_q;

  // Alignment check on the incoming request: offset must be a multiple of the size.
  always_comb begin
    misaligned = 1'b0;
    case (req_size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = req_addr[0];
      2'b10:   misaligned = |req_addr[1:0];
      default: misaligned = |req_addr[2:0];
    endcase
  end

  // Lane extraction for loads and lane merge for sub-word stores.
  always_comb begin
    shift      = {off_q, 3'b000};
    rd_shifted = MemReadData >> shift;
    load_ext   = rd_shifted;
    size_mask  = '1;
    case (size_q)
      2'b00: begin
        load_ext  = {{56{signed_q & rd_shifted[7]}}, rd_shifted[7:0]};
        size_mask = 64'h0000_0000_0000_00FF;
      end
      2'b01: begin
        load_ext  = {{48{signed_q & rd_shifted[15]}}, rd_shifted[15:0]};
        size_mask = 64'h0000_0000_0000_FFFF;
      end
      2'b10: begin
        load_ext  = {{32{signed_q & rd_shifted[31]}}, rd_shifted[31:0]};
        size_mask = 64'h0000_0000_FFFF_FFFF;
      end
      default: begin
        load_ext  = rd_shifted;
        size_mask = '1;
      end
    endcase
    lane_mask = size_mask << shift;
    merged    = (MemReadData & ~lane_mask) | ((wdata_q << shift) & lane_mask);
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_err)                              state_nxt = RESP;
          else if (!req_write || req_size != 2'b11) state_nxt = RD_REQ;
          else                                      state_nxt = WR;
        end
      end
      RD_REQ:  state_nxt = RD_WAIT;
      RD_WAIT: state_nxt = write_q ? WR : RESP;
      WR:      state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Request capture, memory address/data and response data registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      write_q      <= 1'b0;
      signed_q     <= 1'b0;
      err_q        <= 1'b0;
      size_q       <= '0;
      off_q        <= '0;
      wdata_q      <= '0;
      MemAdress    <= '0;
      MemWriteData <= '0;
      resp_rdata   <= '0;
    end else if (accept) begin
      write_q    <= req_write;
      signed_q   <= req_signed;
      err_q      <= req_err;
      size_q     <= req_size;
      off_q      <= req_addr[2:0];
      wdata_q    <= req_wdata;
      MemAdress  <= {3'b000, req_addr[63:3]};
      resp_rdata <= '0;
      if (!req_err && req_write && req_size == 2'b11)
        MemWriteData <= req_wdata;
    end else if (state == RD_WAIT) begin
      if (write_q) MemWriteData <= merged;
      else         resp_rdata   <= load_ext;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural synchronous-read memory.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = '0;
  logic        req_signed = 1'b0;
  logic [63:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic [63:0] MemAdress;
  logic [63:0] MemWriteData;
  logic        MemWrite;
  logic        MemRead;
  logic [63:0] MemReadData;

  load_store_unit #(.MEM_WORDS(1024)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .MemAdress(MemAdress), .MemWriteData(MemWriteData),
    .MemWrite(MemWrite), .MemRead(MemRead), .MemReadData(MemReadData)
  );

  always #5 clk = ~clk;

  // Data memory model: synchronous read, registered write.
  logic [63:0] mem [0:1023];
  logic [63:0] rdq = '0;
  assign MemReadData = rdq;
  always @(posedge clk) begin
    if (MemWrite) mem[MemAdress[9:0]] <= MemWriteData;
    if (MemRead)  rdq <= mem[MemAdress[9:0]];
  end

  // Strobe / response monitors sampled on the falling edge.
  int unsigned rd_cnt = 0, wr_cnt = 0, resp_cnt = 0, overlap_cnt = 0;
  always @(negedge clk) begin
    if (MemRead)             rd_cnt++;
    if (MemWrite)            wr_cnt++;
    if (resp_valid)          resp_cnt++;
    if (MemRead && MemWrite) overlap_cnt++;
  end

  int unsigned checks = 0, fails = 0;

  task automatic chk(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s[%0d]: got 0x%h expected 0x%h", name, idx, act, exp);
    end
  endtask

  typedef struct {
    logic        wr;
    logic [1:0]  sz;
    logic        sg;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] exp_rdata;
    logic        exp_err;
    int unsigned lat;
    int unsigned nrd;
    int unsigned nwr;
  } vec_t;

  function automatic vec_t mk(input logic wr, input logic [1:0] sz, input logic sg,
                              input logic [63:0] addr, input logic [63:0] wdata,
                              input logic [63:0] exp_rdata, input logic exp_err,
                              input int unsigned lat, input int unsigned nrd, input int unsigned nwr);
    vec_t v;
    v.wr = wr; v.sz = sz; v.sg = sg; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.lat = lat; v.nrd = nrd; v.nwr = nwr;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    req_valid  = 1'b1;
    req_write  = v.wr;
    req_size   = v.sz;
    req_signed = v.sg;
    req_addr   = v.addr;
    req_wdata  = v.wdata;
  endtask

  // Issue one request, measure latency and strobes, and check the response.
  task automatic run_req(input vec_t v, input int idx);
    int unsigned rd0, wr0, cyc, guard;
    @(negedge clk);
    drive(v);
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) begin
      chk("ready_timeout", idx, 64'(req_ready), 64'd1);
      req_valid = 1'b0;
    end else begin
      rd0 = rd_cnt;
      wr0 = wr_cnt;
      @(negedge clk);
      req_valid = 1'b0;
      cyc = 1;
      while (!resp_valid && cyc < 10) begin
        @(negedge clk);
        cyc++;
      end
      chk("latency", idx, 64'(cyc), 64'(v.lat));
      chk("rdata", idx, resp_rdata, v.exp_rdata);
      chk("err", idx, 64'(resp_err), 64'(v.exp_err));
      #1;
      chk("memread_pulses", idx, 64'(rd_cnt - rd0), 64'(v.nrd));
      chk("memwrite_pulses", idx, 64'(wr_cnt - wr0), 64'(v.nwr));
    end
  endtask

  vec_t tv [22];

  initial begin
    int unsigned rv0, wr0, nresp, guard;
    int unsigned resp_cyc [2];
    logic [63:0] resp_dat [2];

    tv[0]  = mk(1, 2'b11, 0, 64'h28,   64'h5,                  64'h0,                  0, 2, 0, 1);
    tv[1]  = mk(0, 2'b11, 0, 64'h28,   64'h0,                  64'h5,                  0, 3, 1, 0);
    tv[2]  = mk(1, 2'b11, 0, 64'h40,   64'h80FF,               64'h0,                  0, 2, 0, 1);
    tv[3]  = mk(0, 2'b00, 1, 64'h40,   64'h0,                  64'hFFFF_FFFF_FFFF_FFFF, 0, 3, 1, 0);
    tv[4]  = mk(0, 2'b00, 0, 64'h41,   64'h0,                  64'h80,                 0, 3, 1, 0);
    tv[5]  = mk(0, 2'b01, 1, 64'h40,   64'h0,                  64'hFFFF_FFFF_FFFF_80FF, 0, 3, 1, 0);
    tv[6]  = mk(1, 2'b01, 0, 64'h44,   64'hFFFF_FFFF_1234_BEEF, 64'h0,                 0, 4, 1, 1);
    tv[7]  = mk(0, 2'b11, 0, 64'h40,   64'h0,                  64'h0000_BEEF_0000_80FF, 0, 3, 1, 0);
    tv[8]  = mk(0, 2'b01, 0, 64'h43,   64'h0,                  64'h0,                  1, 1, 0, 0);
    tv[9]  = mk(0, 2'b11, 0, 64'h2000, 64'h0,                  64'h0,                  1, 1, 0, 0);
    tv[10] = mk(1, 2'b11, 0, 64'h1FF8, 64'hDEAD_BEEF_CAFE_F00D, 64'h0,                 0, 2, 0, 1);
    tv[11] = mk(0, 2'b11, 1, 64'h1FF8, 64'h0,                  64'hDEAD_BEEF_CAFE_F00D, 0, 3, 1, 0);
    tv[12] = mk(1, 2'b10, 0, 64'h40,   64'h8000_0001,          64'h0,                  0, 4, 1, 1);
    tv[13] = mk(0, 2'b10, 1, 64'h40,   64'h0,                  64'hFFFF_FFFF_8000_0001, 0, 3, 1, 0);
    tv[14] = mk(0, 2'b10, 0, 64'h40,   64'h0,                  64'h0000_0000_8000_0001, 0, 3, 1, 0);
    tv[15] = mk(1, 2'b10, 0, 64'h42,   64'h1234,               64'h0,                  1, 1, 0, 0);
    tv[16] = mk(1, 2'b00, 0, 64'h47,   64'h5A,                 64'h0,                  0, 4, 1, 1);
    tv[17] = mk(0, 2'b11, 0, 64'h40,   64'h0,                  64'h5A00_BEEF_8000_0001, 0, 3, 1, 0);
    tv[18] = mk(0, 2'b00, 1, 64'h44,   64'h0,                  64'hFFFF_FFFF_FFFF_FFEF, 0, 3, 1, 0);
    tv[19] = mk(0, 2'b01, 1, 64'h46,   64'h0,                  64'h5A00,               0, 3, 1, 0);
    tv[20] = mk(1, 2'b11, 0, 64'h48,   64'h1122_3344_5566_7788, 64'h0,                 0, 2, 0, 1);
    tv[21] = mk(0, 2'b01, 1, 64'h4E,   64'h0,                  64'h1122,               0, 3, 1, 0);

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 0, 64'(req_ready), 64'd1);
    chk("rst_resp_valid", 0, 64'(resp_valid), 64'd0);
    chk("rst_resp_err", 0, 64'(resp_err), 64'd0);
    chk("rst_memread", 0, 64'(MemRead), 64'd0);
    chk("rst_memwrite", 0, 64'(MemWrite), 64'd0);
    chk("rst_resp_rdata", 0, resp_rdata, 64'd0);
    chk("rst_memadress", 0, MemAdress, 64'd0);
    chk("rst_memwritedata", 0, MemWriteData, 64'd0);
    reset = 1'b0;

    for (int i = 0; i < 22; i++) begin
      run_req(tv[i], i);
      if (i == 1 || i == 7) chk("memadress", i, MemAdress, {3'b000, tv[i].addr[63:3]});
    end

    // Sub-word store abandoned by reset during RD_WAIT.
    @(negedge clk);
    drive(mk(1, 2'b00, 0, 64'h48, 64'hAA, 64'h0, 0, 0, 0, 0));
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    rv0 = resp_cnt;
    wr0 = wr_cnt;
    @(negedge clk);
    req_valid = 1'b0;
    chk("abort_rd_req", 0, 64'(MemRead), 64'd1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort_memwrite", 0, 64'(MemWrite), 64'd0);
    chk("abort_ready_in_reset", 0, 64'(req_ready), 64'd1);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("abort_ready", 0, 64'(req_ready), 64'd1);
    chk("abort_no_resp", 0, 64'(resp_cnt - rv0), 64'd0);
    chk("abort_no_write", 0, 64'(wr_cnt - wr0), 64'd0);
    run_req(mk(0, 2'b11, 0, 64'h48, 64'h0, 64'h1122_3344_5566_7788, 0, 3, 1, 0), 100);

    // Back-to-back loads with req_valid held high.
    @(negedge clk);
    drive(mk(0, 2'b11, 0, 64'h28, 64'h0, 64'h0, 0, 0, 0, 0));
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    nresp = 0;
    resp_cyc[0] = 0; resp_cyc[1] = 0;
    resp_dat[0] = '0; resp_dat[1] = '0;
    @(negedge clk);
    req_addr = 64'h1FF8;
    for (int c = 1; c <= 9; c++) begin
      if (c == 4) chk("b2b_ready", c, 64'(req_ready), 64'd1);
      else if (c <= 7) chk("b2b_ready", c, 64'(req_ready), 64'd0);
      if (resp_valid) begin
        if (nresp < 2) begin
          resp_cyc[nresp] = c;
          resp_dat[nresp] = resp_rdata;
        end
        nresp++;
      end
      if (c == 5) req_valid = 1'b0;
      @(negedge clk);
    end
    chk("b2b_resp_count", 0, 64'(nresp), 64'd2);
    chk("b2b_resp0_cycle", 0, 64'(resp_cyc[0]), 64'd3);
    chk("b2b_resp0_data", 0, resp_dat[0], 64'h5);
    chk("b2b_resp1_cycle", 1, 64'(resp_cyc[1]), 64'd7);
    chk("b2b_resp1_data", 1, resp_dat[1], 64'hDEAD_BEEF_CAFE_F00D);

    chk("strobe_overlap", 0, 64'(overlap_cnt), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
